// File: rtl/fifo_word_packer_if.sv
// Bundles the FIFO read side and the packed-word output port of fifo_word_packer.
// master is the packer's view; slave is the FIFO/consumer view.
interface fifo_word_packer_if #(
  parameter int in_width = 8,
  parameter int ratio    = 8
);
  localparam int COUNT_W = $clog2(ratio + 1);

  logic                      fifo_empty;
  logic [in_width-1:0]       fifo_rd_data;
  logic                      fifo_pop;
  logic                      flush;
  logic                      out_valid;
  logic                      out_stall;
  logic [in_width*ratio-1:0] out_data;
  logic [COUNT_W-1:0]        out_count;
  logic                      out_last;
  logic                      flush_done;

  modport master (
    input  fifo_empty, fifo_rd_data, flush, out_stall,
    output fifo_pop, out_valid, out_data, out_count, out_last, flush_done
  );

  modport slave (
    output fifo_empty, fifo_rd_data, flush, out_stall,
    input  fifo_pop, out_valid, out_data, out_count, out_last, flush_done
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Packs `ratio` show-ahead FIFO entries LSB-first into one word; word valid the edge its last entry pops.
// Pops stall only when a completing entry has no free output register; flush emits a tagged partial word.
module fifo_word_packer #(
  parameter int in_width = 8,
  parameter int ratio    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_word_packer_if.master   bus
);
  localparam int CNT_W   = $clog2(ratio);
  localparam int COUNT_W = $clog2(ratio + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ratio - 1);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [ratio-2:0][in_width-1:0]      acc_q, acc_d;
  logic                                out_valid_q, out_valid_d;
  logic [ratio-1:0][in_width-1:0]      out_data_q, out_data_d;
  logic [COUNT_W-1:0]                  out_count_q, out_count_d;
  logic                                out_last_q, out_last_d;
  logic                                flush_done_q, flush_done_d;

  logic cnt_last;
  logic out_free;
  logic pop;

  always_comb begin
    cnt_last = (cnt_q == CNT_LAST);
    out_free = !out_valid_q || !bus.out_stall;
    pop      = !reset && !bus.fifo_empty && !(cnt_last && !out_free);

    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_last_d   = out_last_q;
    flush_done_d = 1'b0;

    if (out_valid_q && !bus.out_stall) begin
      out_valid_d = 1'b0;
    end

    // A completing pop may load while the previous word transfers in the same cycle.
    if (pop) begin
      if (!cnt_last) begin
        for (int k = 0; k < ratio - 1; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            acc_d[k] = bus.fifo_rd_data;
          end
        end
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        out_data_d  = {bus.fifo_rd_data, acc_q};
        out_count_d = COUNT_W'(ratio);
        out_last_d  = 1'b0;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end

    case (state_q)
      RUN: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.fifo_empty && out_free) begin
          if (cnt_q != '0) begin
            for (int k = 0; k < ratio - 1; k++) begin
              out_data_d[k] = (CNT_W'(k) < cnt_q) ? acc_q[k] : '0;
            end
            out_data_d[ratio-1] = '0;
            out_count_d = COUNT_W'(cnt_q);
            out_last_d  = 1'b1;
            out_valid_d = 1'b1;
            cnt_d       = '0;
          end
          flush_done_d = 1'b1;
          state_d      = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_count_q  <= '0;
      out_last_q   <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_last_q   <= out_last_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.fifo_pop   = pop;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_count  = out_count_q;
  assign bus.out_last   = out_last_q;
  assign bus.flush_done = flush_done_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a byte-stream model predicts words; a monitor checks transfers.
module tb_fifo_word_packer;
  localparam int IW = 8;
  localparam int R  = 4;
  localparam int W  = IW * R;

  typedef struct {
    logic [W-1:0] d;
    int           c;
    bit           l;
  } exp_t;

  logic clk;
  logic reset;

  fifo_word_packer_if #(.in_width(IW), .ratio(R)) bus();

  fifo_word_packer #(.in_width(IW), .ratio(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] fifoq[$];
  logic [7:0] pend[$];
  exp_t       expq[$];
  int         xfer_cyc[$];
  bit         busy = 0;
  int         exp_fd = 0;
  int         got_fd = 0;
  int         cyc = 0;
  bit         last_pop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void make_exp(input bit l);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < pend.size(); k++) w[k*IW +: IW] = pend[k];
    expq.push_back('{d: w, c: pend.size(), l: l});
    pend.delete();
  endfunction

  // Stream-level reference: every R pushed bytes form a word; an accepted flush closes the tail.
  task automatic push_byte(input logic [7:0] b);
    fifoq.push_back(b);
    pend.push_back(b);
    if (pend.size() == R) make_exp(1'b0);
  endtask

  task automatic tick(input bit stall_v, input bit flush_v, input bit rst_v);
    if (bus.flush_done === 1'b1) busy = 0;
    reset          = rst_v;
    bus.out_stall  = stall_v;
    bus.flush      = flush_v;
    bus.fifo_empty = (fifoq.size() == 0);
    bus.fifo_rd_data = (fifoq.size() == 0) ? 8'h00 : fifoq[0];
    if (rst_v) begin
      pend.delete();
      expq.delete();
      busy = 0;
    end else if (flush_v && !busy) begin
      busy = 1;
      exp_fd++;
      if (pend.size() > 0) make_exp(1'b1);
    end
    #1;
    last_pop = bus.fifo_pop;
    if (rst_v) check("pop_in_reset", 64'(last_pop), 64'd0);
    else if (!stall_v) check("pop_no_stall", 64'(last_pop), 64'(fifoq.size() != 0));
    @(posedge clk);
    if (last_pop) void'(fifoq.pop_front());
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_fd();
    int n;
    n = 0;
    while (bus.flush_done !== 1'b1 && n < 100) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("flush_done_seen", 64'(bus.flush_done), 64'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_data"},  64'(bus.out_data), 64'd0);
    check({tag, "_count"}, 64'(bus.out_count), 64'd0);
    check({tag, "_last"},  64'(bus.out_last), 64'd0);
    check({tag, "_fdone"}, 64'(bus.flush_done), 64'd0);
  endtask

  // Monitor: compares every transfer against the scoreboard and checks hold stability under stall.
  initial begin
    bit           prev_hold;
    bit           prev_fd;
    logic [W-1:0] pd;
    logic [2:0]   pc;
    logic         pl;
    exp_t         e;
    prev_hold = 0;
    prev_fd   = 0;
    pd = '0; pc = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_hold) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data",  64'(bus.out_data), 64'(pd));
        check("hold_count", 64'(bus.out_count), 64'(pc));
        check("hold_last",  64'(bus.out_last), 64'(pl));
      end
      if (bus.flush_done === 1'b1) begin
        got_fd++;
        check("flush_done_pulse", 64'(prev_fd), 64'd0);
      end
      if (bus.out_valid === 1'b1 && bus.out_stall === 1'b0) begin
        xfer_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got %0h, expected no word (cycle %0d)", bus.out_data, cyc);
        end else begin
          e = expq.pop_front();
          check("word_data",  64'(bus.out_data), 64'(e.d));
          check("word_count", 64'(bus.out_count), 64'(e.c));
          check("word_last",  64'(bus.out_last), 64'(e.l));
        end
      end
      prev_hold = (bus.out_valid === 1'b1) && (bus.out_stall === 1'b1) && (reset === 1'b0);
      prev_fd   = (bus.flush_done === 1'b1);
      pd = bus.out_data;
      pc = bus.out_count;
      pl = bus.out_last;
    end
  end

  initial begin
    int pops;
    int n0;
    int n;
    reset          = 1'b1;
    bus.out_stall  = 1'b1;
    bus.flush      = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_rd_data = '0;

    repeat (2) tick(1'b1, 1'b0, 1'b1);
    check_cleared("reset");

    // One full word, pops on four consecutive cycles, valid right after the completing pop.
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    pops = 0;
    repeat (4) begin
      tick(1'b0, 1'b0, 1'b0);
      pops += int'(last_pop);
    end
    check("t1_pops", 64'(pops), 64'd4);
    check("t1_valid", 64'(bus.out_valid), 64'd1);
    check("t1_data", 64'(bus.out_data), 64'h44332211);
    check("t1_count", 64'(bus.out_count), 64'd4);
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // Twelve bytes back-to-back: three words exactly R cycles apart.
    for (int i = 0; i < 12; i++) push_byte(8'h50 + 8'(i));
    n0 = xfer_cyc.size();
    repeat (16) tick(1'b0, 1'b0, 1'b0);
    check("t2_words", 64'(xfer_cyc.size() - n0), 64'd3);
    if (xfer_cyc.size() - n0 == 3) begin
      check("t2_gap0", 64'(xfer_cyc[n0+1] - xfer_cyc[n0]), 64'(R));
      check("t2_gap1", 64'(xfer_cyc[n0+2] - xfer_cyc[n0+1]), 64'(R));
    end

    // Held stall: popping stops with one byte left and the first word held.
    for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
    repeat (12) tick(1'b1, 1'b0, 1'b0);
    check("t3_left", 64'(fifoq.size()), 64'd1);
    check("t3_pop_stop", 64'(last_pop), 64'd0);
    check("t3_valid", 64'(bus.out_valid), 64'd1);
    check("t3_data", 64'(bus.out_data), 64'hC3C2C1C0);
    repeat (10) tick(1'b0, 1'b0, 1'b0);

    // Six bytes then flush: full word then a 2-entry tail tagged last.
    for (int i = 0; i < 6; i++) push_byte(8'hA0 + 8'(i));
    tick(1'b0, 1'b1, 1'b0);
    wait_fd();
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    // Exact multiple then flush, with a second flush during DRAIN.
    for (int i = 0; i < 4; i++) push_byte(8'h70 + 8'(i));
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    wait_fd();
    repeat (6) tick(1'b0, 1'b0, 1'b0);

    // Flush latency with FIFO empty and output free.
    push_byte(8'h5A); push_byte(8'h5B);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("t6_fd_early", 64'(bus.flush_done), 64'd0);
    check("t6_valid_early", 64'(bus.out_valid), 64'd0);
    tick(1'b0, 1'b0, 1'b0);
    check("t6_fd", 64'(bus.flush_done), 64'd1);
    check("t6_valid", 64'(bus.out_valid), 64'd1);
    check("t6_data", 64'(bus.out_data), 64'h00005B5A);
    check("t6_count", 64'(bus.out_count), 64'd2);
    check("t6_last", 64'(bus.out_last), 64'd1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);

    // Reset with a stalled word and a half-filled accumulator.
    for (int i = 0; i < 6; i++) push_byte(8'hE0 + 8'(i));
    repeat (8) tick(1'b1, 1'b0, 1'b0);
    check("t7_empty", 64'(fifoq.size()), 64'd0);
    check("t7_valid_pre", 64'(bus.out_valid), 64'd1);
    tick(1'b1, 1'b0, 1'b1);
    check_cleared("t7_reset");
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    check("t7_data", 64'(bus.out_data), 64'h04030201);
    check("t7_count", 64'(bus.out_count), 64'd4);
    repeat (2) tick(1'b0, 1'b0, 1'b0);

    // Random traffic, stalls and flushes.
    repeat (600) begin
      bit st;
      bit fl;
      if (!busy && $urandom_range(0, 2) != 0) push_byte(8'($urandom_range(0, 255)));
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 39) == 0);
      tick(st, fl, 1'b0);
    end
    n = 0;
    while ((fifoq.size() > 0 || busy || bus.out_valid === 1'b1) && n < 500) begin
      tick(1'b0, 1'b0, 1'b0);
      n++;
    end
    check("drain_bounded", 64'(n < 500), 64'd1);
    tick(1'b0, 1'b1, 1'b0);
    wait_fd();
    repeat (4) tick(1'b0, 1'b0, 1'b0);

    check("scoreboard_empty", 64'(expq.size()), 64'd0);
    check("flush_done_total", 64'(got_fd), 64'(exp_fd));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer stage for `sync_fifo`. Pops narrow entries from the FIFO's read side and packs `ratio` consecutive entries into one wide word, LSB-first. It presents each word on a valid/stall output port toward the memory-write path. A flush input drains the FIFO and emits any partial word tagged with its byte count, so stream tails are never stranded.

## Interface
- `in_width`, 8, width of one FIFO entry (matches the `sync_fifo` `width`)
- `ratio`, 8, entries per output word; must be ≥2
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `fifo_empty`  in  1  `sync_fifo` `empty`
- `fifo_rd_data`  in  `in_width`  `sync_fifo` `rd_data`; show-ahead, valid whenever `fifo_empty`=0
- `fifo_pop`  out  1  to `sync_fifo` `pop`
- `flush`  in  1  one-cycle request: drain and emit partial word
- `out_valid`  out  1  output word held valid
- `out_stall`  in  1  consumer cannot accept this cycle
- `out_data`  out  `in_width*ratio`  packed word; entry k at bits [k*in_width +: in_width]
- `out_count`  out  clog2(`ratio`+1)  valid entries in `out_data` (= `ratio` for full words)
- `out_last`  out  1  word was produced by a flush
- `flush_done`  out  1  one-cycle pulse when a flush completes

## Operation
- Internal state: accumulator (`ratio`-1 entries), index `cnt` (0..`ratio`-1), one output register, FSM {RUN, DRAIN}.
- `out_free` = !`out_valid` | !`out_stall`. This is true when the output register is empty or is transferring this cycle.
- Pop rule: `fifo_pop` = !`fifo_empty` & !(`cnt`==`ratio`-1 & !`out_free`). Pops stop only when the popped entry would complete a word that has nowhere to go.
- On pop with `cnt`<`ratio`-1: store `fifo_rd_data` at slot `cnt`; `cnt`++.
- On pop with `cnt`==`ratio`-1: load the output register with the accumulator plus `fifo_rd_data` in the top slot; `out_count`=`ratio`, `out_last`=0, `out_valid`=1; `cnt`=0.
- Transfer: `out_valid` & !`out_stall`. After a transfer with no new load, `out_valid`=0. A load and a transfer in the same cycle are legal; the new word replaces the old one and `out_valid` stays 1.
- `out_data`, `out_count` and `out_last` are held stable while `out_valid` & `out_stall`.
- FSM:
  - RUN: `flush`=1 → DRAIN. Popping continues normally in that cycle.
  - DRAIN: keeps popping per the pop rule. `flush` is ignored; requests do not queue. DRAIN completes in the first cycle with `fifo_empty`=1 and `out_free`=1:
    - If `cnt`>0: load the output register with the accumulator, unused slots zero, `out_count`=`cnt`, `out_last`=1; `cnt`=0.
    - If `cnt`==0: no word is emitted.
    - In both cases: `flush_done`=1 for one cycle, then → RUN.
  - DRAIN while `fifo_empty`=1 but `out_free`=0: wait.
- An exact multiple of `ratio` entries followed by a flush emits no extra word. The final full word keeps `out_last`=0.
- Entries the FIFO receives during DRAIN are packed as long as `fifo_empty`=0 in those cycles.

## Timing
- `fifo_pop` is combinational from `fifo_empty`, `out_valid`, `out_stall` and `cnt`. `fifo_rd_data` is sampled on the same edge.
- Latency: completing entry popped at edge N → `out_valid`=1 from edge N, visible in cycle N+1.
- Sustained throughput: one entry per cycle, one word per `ratio` cycles, with no bubble at word boundaries while the consumer does not stall.
- Flush: `flush` at edge F with the FIFO already empty and the output free → partial word `out_valid` and `flush_done` both visible after edge F+1.
- Reset, synchronous, takes priority over all events:
  - `out_valid`=0, `out_data`=0, `out_count`=0, `out_last`=0, `flush_done`=0.
  - `cnt`=0, FSM=RUN, accumulator cleared.
  - A pending flush or any partial/unaccepted word is discarded.
  - `fifo_pop`=0 while `reset`=1.

## Test plan
- `ratio`=4, bytes 0x11,0x22,0x33,0x44 streamed with no stall → one word 0x44332211, `out_count`=4, `out_last`=0; `fifo_pop` high 4 consecutive cycles.
- 12 bytes back-to-back, `out_stall`=0 → 3 words on consecutive 4-cycle boundaries, no pop gaps.
- 8 bytes with `out_stall`=1 held throughout → first word held stable; `fifo_pop` drops at the 8th byte with `cnt`=3; after release, both words emerge in order with no data loss.
- 6 bytes 0xA0..0xA5 then `flush` → full word 0xA3A2A1A0; then 0x0000A5A4 with `out_count`=2, `out_last`=1, `flush_done` pulse.
- 4 bytes then `flush` → one full word, no partial word; `flush_done` pulse; a second `flush` during DRAIN has no extra effect.
- Reset asserted with `cnt`=2 and `out_valid`=1 stalled → next cycle all outputs 0; subsequent 4 bytes pack from slot 0.
